// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle integer divider.
// Covers the default width, the FSM state encodings and the divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Quotient reported for any division by zero, independent of signedness.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the divider.
// The master drives the operands and the level-held start; the slave returns ready and the result.
interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic               div_sign;
    logic               div_start_i;
    logic [WIDTH-1:0]   div_op1;
    logic [WIDTH-1:0]   div_op2;
    logic               div_ready;
    logic               div_zero;
    logic [2*WIDTH-1:0] result;

    modport master (
        output div_sign, div_start_i, div_op1, div_op2,
        input  div_ready, div_zero, result
    );

    modport slave (
        input  div_sign, div_start_i, div_op1, div_op2,
        output div_ready, div_zero, result
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step, purely combinational.
// Shifts the next dividend bit into the partial remainder and subtracts the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] rem_sh;
    logic           fits;

    // The extra top bit keeps the comparison exact when the shifted remainder overflows WIDTH bits.
    assign rem_sh  = {rem, q[WIDTH-1]};
    assign fits    = rem_sh >= {1'b0, divisor};
    assign rem_nxt = fits ? WIDTH'(rem_sh - {1'b0, divisor}) : rem_sh[WIDTH-1:0];
    assign q_nxt   = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: restoring division on operand magnitudes, then a sign fix-up.
// Returns {remainder, quotient} to the HI/LO write-back path under a level-held start/ready handshake.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic  clk,
    input  logic  resetn,
    div_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    div_state_t         state;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   op1_orig;
    logic [CW-1:0]      count;
    logic               neg_q;
    logic               neg_r;
    logic               zero;
    logic               ready_r;
    logic               zero_r;
    logic [2*WIDTH-1:0] result_r;

    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [WIDTH-1:0]   op1_mag;
    logic [WIDTH-1:0]   op2_mag;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .q       (q),
        .divisor (divisor),
        .rem_nxt (rem_nxt),
        .q_nxt   (q_nxt)
    );

    assign op1_mag = (bus.div_sign && bus.div_op1[WIDTH-1]) ? -bus.div_op1 : bus.div_op1;
    assign op2_mag = (bus.div_sign && bus.div_op2[WIDTH-1]) ? -bus.div_op2 : bus.div_op2;
    // Negating 0x80000000 yields itself, which is exactly the required overflow quotient.
    assign quo_fix = neg_q ? -q : q;
    assign rem_fix = neg_r ? -rem : rem;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: every register, datapath included, is reset so a mid-operation reset leaves no stale state.
        if (!resetn) begin
            state    <= IDLE;
            q        <= '0;
            rem      <= '0;
            divisor  <= '0;
            op1_orig <= '0;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero     <= 1'b0;
            ready_r  <= 1'b0;
            zero_r   <= 1'b0;
            result_r <= '0;
        end else if (!bus.div_start_i) begin
            state   <= IDLE;
            ready_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    neg_q    <= bus.div_sign & (bus.div_op1[WIDTH-1] ^ bus.div_op2[WIDTH-1]);
                    neg_r    <= bus.div_sign & bus.div_op1[WIDTH-1];
                    q        <= op1_mag;
                    divisor  <= op2_mag;
                    op1_orig <= bus.div_op1;
                    rem      <= '0;
                    count    <= '0;
                    zero     <= (bus.div_op2 == '0);
                    state    <= ITER;
                end
                ITER: begin
                    rem   <= rem_nxt;
                    q     <= q_nxt;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    // Signed division by zero would not naturally produce this, so it is forced.
                    result_r <= zero ? {op1_orig, WIDTH'(DIV_ZERO_QUO)} : {rem_fix, quo_fix};
                    zero_r   <= zero;
                    ready_r  <= 1'b1;
                    state    <= DONE;
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.div_ready = ready_r;
    assign bus.div_zero  = zero_r;
    assign bus.result    = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: signed/unsigned cases, divide by zero, overflow,
// latency, abort, operand stability and asynchronous reset mid-operation.
module tb_div_unit;
    import div_pkg::*;

    logic clk;
    logic resetn;
    int   passed;
    int   total;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    // Runs one operation from IDLE; pert_edge > 0 scrambles the operands after that edge.
    task automatic run_op(input string tag, input logic sign, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [63:0] exp_res,
                          input logic exp_zero, input int pert_edge);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.div_sign    = sign;
        bus.div_op1     = op1;
        bus.div_op2     = op2;
        bus.div_start_i = 1'b1;
        for (int e = 1; e <= 40 && lat == 0; e++) begin
            @(posedge clk);
            #1;
            if (bus.div_ready) lat = e;
            if (e == pert_edge) begin
                bus.div_op1  = ~op1;
                bus.div_op2  = op2 + 32'd3;
                bus.div_sign = ~sign;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_zero"}, 64'(bus.div_zero), 64'(exp_zero));
        @(negedge clk);
        bus.div_start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_ready"}, 64'(bus.div_ready), 64'd0);
    endtask

    initial begin
        passed          = 0;
        total           = 0;
        resetn          = 1'b0;
        bus.div_sign    = 1'b0;
        bus.div_start_i = 1'b0;
        bus.div_op1     = '0;
        bus.div_op2     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(bus.div_ready), 64'd0);
        check("reset_zero", 64'(bus.div_zero), 64'd0);
        check("reset_result", bus.result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("u_100_7",     1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 1'b0, 0);
        run_op("s_m7_2",      1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 1'b0, 0);
        run_op("u_m7_2",      1'b0, 32'hFFFFFFF9,  32'h00000002,  64'h00000001_7FFFFFFC, 1'b0, 0);
        run_op("s_7_m2",      1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 1'b0, 0);
        run_op("s_m8_2",      1'b1, 32'hFFFFFFF8,  32'd2,         64'h00000000_FFFFFFFC, 1'b0, 0);
        run_op("s_overflow",  1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 1'b0, 0);
        run_op("u_div0",      1'b0, 32'h12345678,  32'd0,         64'h12345678_FFFFFFFF, 1'b1, 0);
        run_op("s_div0",      1'b1, 32'h12345678,  32'd0,         64'h12345678_FFFFFFFF, 1'b1, 0);

        // Abort at iteration 10: ready stays low and last result/div_zero are kept.
        @(negedge clk);
        bus.div_sign    = 1'b0;
        bus.div_op1     = 32'd1000;
        bus.div_op2     = 32'd9;
        bus.div_start_i = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("abort_ready_mid", 64'(bus.div_ready), 64'd0);
        @(negedge clk);
        bus.div_start_i = 1'b0;
        @(posedge clk);
        #1;
        check("abort_state", 64'(u_dut.state), 64'(IDLE));
        check("abort_ready", 64'(bus.div_ready), 64'd0);
        check("abort_keep_result", bus.result, 64'h12345678_FFFFFFFF);
        check("abort_keep_zero", 64'(bus.div_zero), 64'd1);
        run_op("u_9_3",       1'b0, 32'd9,         32'd3,         64'h00000000_00000003, 1'b0, 0);

        // Operands and sign scrambled from edge 5 onward must not affect the result.
        run_op("stable_ops",  1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 1'b0, 5);

        // Asynchronous reset between edges mid-ITER.
        @(negedge clk);
        bus.div_sign    = 1'b1;
        bus.div_op1     = 32'hFFFFFFF9;
        bus.div_op2     = 32'd2;
        bus.div_start_i = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_async_ready", 64'(bus.div_ready), 64'd0);
        check("rst_async_result", bus.result, 64'd0);
        check("rst_async_state", 64'(u_dut.state), 64'(IDLE));
        bus.div_start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_op("after_rst",   1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the CPU execute stage; the inverse companion of the multiplier unit. It serves DIV and DIVU.
- Uses the same level-held start / ready handshake as the multiplier.
- Produces the quotient (LO) and remainder (HI) packed into one 64-bit result for the HI/LO write-back path.
- Radix-2 restoring algorithm on operand magnitudes, with a final sign fix-up.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- div_sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- div_start_i  in  1  level request; held high until div_ready is seen; low aborts.
- div_op1  in  WIDTH  dividend; sampled at start.
- div_op2  in  WIDTH  divisor; sampled at start.
- div_ready  out  1  result valid; high in DONE while div_start_i stays high.
- div_zero  out  1  divisor was zero for the current/last result.
- result  out  2*WIDTH  {remainder, quotient}: [63:32] = HI, [31:0] = LO.

Behaviour:
- Reset: resetn low asynchronously forces state=IDLE, div_ready=0, div_zero=0, result=0, and all internal registers to 0. This applies at any time, including mid-operation.
- States: IDLE, ITER, FIX, DONE (2-bit encoding).
- IDLE, on the edge where div_start_i=1:
  - Latch sign control: neg_q = div_sign & (op1[31]^op2[31]); neg_r = div_sign & op1[31].
  - Latch |op1| into the quotient/shift register and |op2| into the divisor register. Magnitude is taken only when div_sign=1 and the MSB is set.
  - Clear the partial remainder; set count=0; zero = (op2==0); go to ITER.
- ITER, one step per edge:
  - Form rem' = {rem[WIDTH-1:0], q[WIDTH-1]} as a WIDTH+1-bit value.
  - If rem' >= divisor: rem = rem' - divisor and shift 1 into q[0]; else rem = rem' and shift 0 into q[0].
  - count increments; after the WIDTH-th step (count==WIDTH-1) go to FIX.
- FIX, one edge:
  - Quotient output = neg_q ? -q : q; remainder output = neg_r ? -rem : rem.
  - Write result; div_zero <= zero; div_ready <= 1; go to DONE.
- DONE: result and div_ready are held while div_start_i=1.
- Latency: start sampled at edge 1; div_ready is high after edge WIDTH+2 (edge 34 for WIDTH=32).
- div_start_i low in any state: synchronous return to IDLE on the next edge, div_ready <= 0, iteration discarded. result and div_zero keep their last completed value.
- A new operation needs div_start_i low for at least one edge, so that IDLE is re-entered.
- Operand or div_sign changes after the start edge are ignored.
- Divide by zero: result = {original div_op1, all-ones}, div_zero=1, same latency, regardless of div_sign. This falls out of the restoring algorithm on |op1| only for unsigned; the FIX state forces the value.
- Overflow 0x80000000 / 0xFFFFFFFF signed:
  - |op1| = 0x80000000 unsigned and |op2| = 1, so q = 0x80000000 and rem = 0.
  - Negation leaves q = 0x80000000; no flag is raised.
- Remainder sign follows the dividend; a zero remainder is never negated to a nonzero value.

Decomposition:
- Shared package div_pkg: DIV_WIDTH=32 default; state encodings IDLE/ITER/FIX/DONE; DIV_ZERO_QUO = all-ones constant.
- One sub-module div_step: combinational single restoring step. It takes rem, q, and divisor, and returns next rem and next q. It is instantiated once in ITER.
- Counter, FSM, magnitude/negate logic and result register stay in div_unit.

Test Plan:
- Unsigned 100/7, div_sign=0: result = 64'h00000002_0000000E; div_ready first high after edge 34, not at edge 33.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): result = 64'hFFFFFFFF_FFFFFFFD (rem -1, quo -3). Same operands unsigned: quo 0x7FFFFFFC, rem 0x00000001.
- Signed overflow 0x80000000 / 0xFFFFFFFF: result = 64'h00000000_80000000, div_zero=0.
- Divide by zero, 0x12345678 / 0, both signs: result = 64'h12345678_FFFFFFFF, div_zero=1, latency 34.
- Abort and operand stability:
  - Drop div_start_i at iteration 10: div_ready stays 0 and state returns to IDLE next edge.
  - Re-raise with 9/3: result = 64'h00000000_00000003 after 34 edges.
  - Toggling div_op1 mid-ITER does not change the result.
- Reset mid-ITER: drive resetn low between edges; div_ready and result go to 0 immediately, before any clock edge. Restart after release completes normally.
